// File: rtl/hdmi_audio_rate_sampler_if.sv
// Audio sample path between the FM demodulator and the HDMI packetiser:
// run/filter/clear controls, the input sample stream and the converted
// output samples with underrun status.
interface hdmi_audio_rate_sampler_if #(
  parameter int CHANNELS  = 2,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16
);
  logic                          en;
  logic                          filt_en;
  logic                          clr;
  logic                          in_valid;
  logic [CHANNELS*IN_WIDTH-1:0]  in_data;
  logic                          out_strobe;
  logic [CHANNELS*OUT_WIDTH-1:0] out_data;
  logic                          underrun;
  logic [15:0]                   underrun_cnt;

  // Sample source / controller side
  modport master (
    output en, filt_en, clr, in_valid, in_data,
    input  out_strobe, out_data, underrun, underrun_cnt
  );

  // Sampler side
  modport slave (
    input  en, filt_en, clr, in_valid, in_data,
    output out_strobe, out_data, underrun, underrun_cnt
  );
endinterface

// File: rtl/hdmi_audio_rate_sampler.sv
// Audio-rate sampler: a fractional-N phase accumulator derives an exact
// audio tick from clk_pixel; each channel runs an optional first-order IIR
// (coefficient 2^-SHIFT), and on every tick the filtered samples are
// rounded/saturated (or widened) to OUT_WIDTH and latched. Ticks that find
// no new input since the previous tick are counted as underruns.
module hdmi_audio_rate_sampler #(
  parameter int CHANNELS  = 2,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int PHASE_W   = 32,
  parameter int RATE_INC  = 48000,
  parameter int RATE_MOD  = 25175000,
  parameter int SHIFT     = 2
) (
  input logic                      clk_pixel,
  input logic                      sys_nrst,
  hdmi_audio_rate_sampler_if.slave bus
);

  // Filter state keeps SHIFT fractional bits plus one guard bit.
  localparam int ST_W = IN_WIDTH + SHIFT + 1;
  localparam logic [PHASE_W:0] INC_EXT = (PHASE_W + 1)'(RATE_INC);
  localparam logic [PHASE_W:0] MOD_EXT = (PHASE_W + 1)'(RATE_MOD);

  logic [PHASE_W-1:0]            phase_reg, phase_next;
  logic                          tick_reg, tick_next;
  logic [PHASE_W:0]              phase_sum;
  logic                          fresh_reg;
  logic                          out_strobe_reg;
  logic                          underrun_reg;
  logic [15:0]                   underrun_cnt_reg;
  logic [CHANNELS*OUT_WIDTH-1:0] out_data_reg;
  logic [CHANNELS*OUT_WIDTH-1:0] conv_all;

  // One extra bit so phase+RATE_INC can never wrap before the compare.
  assign phase_sum = {1'b0, phase_reg} + INC_EXT;

  // Next phase and tick: wrap modulo RATE_MOD; a disabled accumulator restarts from 0
  always_comb begin
    phase_next = phase_sum[PHASE_W-1:0];
    tick_next  = 1'b0;
    if (!bus.en) begin
      phase_next = '0;
    end else if (phase_sum >= MOD_EXT) begin
      phase_next = PHASE_W'(phase_sum - MOD_EXT);
      tick_next  = 1'b1;
    end
  end

  // Phase accumulator and registered tick
  always_ff @(posedge clk_pixel or negedge sys_nrst) begin
    if (!sys_nrst) begin
      phase_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      tick_reg  <= tick_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [IN_WIDTH-1:0]  x;
      logic signed [ST_W-1:0]      x_sh;
      logic signed [ST_W-1:0]      diff;
      logic signed [ST_W-1:0]      step;
      logic signed [ST_W-1:0]      st_reg, st_next;
      logic signed [IN_WIDTH-1:0]  smp;
      logic [OUT_WIDTH-1:0]        conv;

      assign x    = bus.in_data[gi*IN_WIDTH +: IN_WIDTH];
      assign x_sh = {{(SHIFT + 1){x[IN_WIDTH-1]}}, x} <<< SHIFT;
      // The difference of two in-range states always fits ST_W bits.
      assign diff = x_sh - st_reg;
      assign step = diff >>> SHIFT;
      assign smp  = IN_WIDTH'(st_reg >>> SHIFT);

      // Filter update: IIR step when enabled, straight load otherwise
      always_comb begin
        st_next = st_reg;
        if (bus.in_valid) begin
          st_next = bus.filt_en ? (st_reg + step) : x_sh;
        end
      end

      // Filter state register
      always_ff @(posedge clk_pixel or negedge sys_nrst) begin
        if (!sys_nrst) begin
          st_reg <= '0;
        end else begin
          st_reg <= st_next;
        end
      end

      if (OUT_WIDTH > IN_WIDTH) begin : g_wide
        assign conv = {smp, {(OUT_WIDTH - IN_WIDTH){1'b0}}};
      end else if (OUT_WIDTH == IN_WIDTH) begin : g_same
        assign conv = smp;
      end else begin : g_narrow
        localparam int D = IN_WIDTH - OUT_WIDTH;
        localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1) << (D - 1);
        logic signed [IN_WIDTH:0]  rnd;
        logic signed [OUT_WIDTH:0] rsh;
        assign rnd = {smp[IN_WIDTH-1], smp} + HALF;
        assign rsh = (OUT_WIDTH + 1)'(rnd >>> D);
        // Rounding can only push past the positive limit, by exactly one LSB.
        assign conv = (!rsh[OUT_WIDTH] && rsh[OUT_WIDTH-1]) ?
                      {1'b0, {(OUT_WIDTH - 1){1'b1}}} : rsh[OUT_WIDTH-1:0];
      end

      assign conv_all[gi*OUT_WIDTH +: OUT_WIDTH] = conv;
    end
  endgenerate

  // Output capture one cycle after the tick, using the pre-update filter state
  always_ff @(posedge clk_pixel or negedge sys_nrst) begin
    if (!sys_nrst) begin
      out_strobe_reg <= 1'b0;
      out_data_reg   <= '0;
    end else begin
      out_strobe_reg <= tick_reg;
      if (tick_reg) begin
        out_data_reg <= conv_all;
      end
    end
  end

  // Fresh flag: new input wins over the tick that would clear it
  always_ff @(posedge clk_pixel or negedge sys_nrst) begin
    if (!sys_nrst) begin
      fresh_reg <= 1'b0;
    end else if (bus.in_valid) begin
      fresh_reg <= 1'b1;
    end else if (tick_reg) begin
      fresh_reg <= 1'b0;
    end
  end

  // Sticky underrun flag and saturating counter; clear has priority
  always_ff @(posedge clk_pixel or negedge sys_nrst) begin
    if (!sys_nrst) begin
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else if (bus.clr) begin
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else if (tick_reg && !fresh_reg) begin
      underrun_reg <= 1'b1;
      if (underrun_cnt_reg != 16'hFFFF) begin
        underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.out_strobe   = out_strobe_reg;
  assign bus.out_data     = out_data_reg;
  assign bus.underrun     = underrun_reg;
  assign bus.underrun_cnt = underrun_cnt_reg;

endmodule

// File: tb/tb_hdmi_audio_rate_sampler.sv
// Directed bench for hdmi_audio_rate_sampler using three instances:
//   u_a: 2 ch, 16->16 bit, rate 1/4, SHIFT=2  (timing, en, filter, underrun, channel order)
//   u_b: 1 ch, 16->12 bit, rate 3/8, SHIFT=0  (tick density, narrowing conversion)
//   u_c: 1 ch, 16->24 bit, rate 3/8, SHIFT=0  (widening conversion)
module tb_hdmi_audio_rate_sampler;

  logic clk_pixel = 1'b0;
  logic sys_nrst  = 1'b0;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_audio_rate_sampler_if #(.CHANNELS(2), .IN_WIDTH(16), .OUT_WIDTH(16)) ifa ();
  hdmi_audio_rate_sampler_if #(.CHANNELS(1), .IN_WIDTH(16), .OUT_WIDTH(12)) ifb ();
  hdmi_audio_rate_sampler_if #(.CHANNELS(1), .IN_WIDTH(16), .OUT_WIDTH(24)) ifc ();

  hdmi_audio_rate_sampler #(
    .CHANNELS(2), .IN_WIDTH(16), .OUT_WIDTH(16), .PHASE_W(32),
    .RATE_INC(1), .RATE_MOD(4), .SHIFT(2)
  ) u_a (.clk_pixel(clk_pixel), .sys_nrst(sys_nrst), .bus(ifa));

  hdmi_audio_rate_sampler #(
    .CHANNELS(1), .IN_WIDTH(16), .OUT_WIDTH(12), .PHASE_W(32),
    .RATE_INC(3), .RATE_MOD(8), .SHIFT(0)
  ) u_b (.clk_pixel(clk_pixel), .sys_nrst(sys_nrst), .bus(ifb));

  hdmi_audio_rate_sampler #(
    .CHANNELS(1), .IN_WIDTH(16), .OUT_WIDTH(24), .PHASE_W(32),
    .RATE_INC(3), .RATE_MOD(8), .SHIFT(0)
  ) u_c (.clk_pixel(clk_pixel), .sys_nrst(sys_nrst), .bus(ifc));

  typedef struct {
    logic [15:0] x;
    logic [11:0] exp12;
    logic [23:0] exp24;
  } conv_vec_t;

  typedef struct {
    logic        fe;
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] e0;
    logic [15:0] e1;
  } filt_vec_t;

  conv_vec_t cv[8];
  filt_vec_t fv[4];
  int        gap_pat[3];

  int n_vec = 0;
  int n_bad = 0;

  int cnt_b, first_b, last_b, bad_gap;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("  ok   %-18s 0x%0h", name, act);
    end
  endtask

  // sel 0 watches u_a, sel 1 watches u_b
  task automatic wait_strobe(input int sel, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_pixel);
      seen = (sel == 0) ? ifa.out_strobe : ifb.out_strobe;
      if (seen) break;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: out_strobe not seen within 16 cycles (got 0, expected 1)", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    // Narrowing 16->12 rounds at 2^3 and saturates; widening appends 8 zero LSBs.
    cv[0] = '{16'h7FF8, 12'h7FF, 24'h7FF800};
    cv[1] = '{16'hFFFF, 12'h000, 24'hFFFF00};
    cv[2] = '{16'h8000, 12'h800, 24'h800000};
    cv[3] = '{16'h0018, 12'h002, 24'h001800};
    cv[4] = '{16'h8001, 12'h800, 24'h800100};
    cv[5] = '{16'h0007, 12'h000, 24'h000700};
    cv[6] = '{16'h0008, 12'h001, 24'h000800};
    cv[7] = '{16'hFFF7, 12'hFFF, 24'hFFF700};
    // ch0 = +1000, ch1 = -1000: +250/+437/+578 and -250/-438/-579, then load 1000/-1000.
    fv[0] = '{1'b1, 16'h03E8, 16'hFC18, 16'h00FA, 16'hFF06};
    fv[1] = '{1'b1, 16'h03E8, 16'hFC18, 16'h01B5, 16'hFE4A};
    fv[2] = '{1'b1, 16'h03E8, 16'hFC18, 16'h0242, 16'hFDBD};
    fv[3] = '{1'b0, 16'h03E8, 16'hFC18, 16'h03E8, 16'hFC18};
    gap_pat = '{3, 2, 3};

    ifa.en = 1'b1; ifa.filt_en = 1'b0; ifa.clr = 1'b0; ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.en = 1'b1; ifb.filt_en = 1'b0; ifb.clr = 1'b0; ifb.in_valid = 1'b0; ifb.in_data = '0;
    ifc.en = 1'b1; ifc.filt_en = 1'b0; ifc.clr = 1'b0; ifc.in_valid = 1'b0; ifc.in_data = '0;

    repeat (3) @(negedge clk_pixel);
    chk("rst_a_strobe", ifa.out_strobe, 0);
    chk("rst_a_data", ifa.out_data, 0);
    chk("rst_a_underrun", ifa.underrun, 0);
    chk("rst_a_cnt", ifa.underrun_cnt, 0);
    chk("rst_b_strobe", ifb.out_strobe, 0);

    // Rate 3/8: first strobe at cycle 4, gaps 3,2,3 repeating, 300 strobes in 800 cycles.
    sys_nrst = 1'b1;
    cnt_b = 0; first_b = 0; last_b = 0; bad_gap = 0;
    for (int c = 1; c <= 803; c++) begin
      @(negedge clk_pixel);
      if (ifb.out_strobe) begin
        if (cnt_b == 0) first_b = c;
        else if ((c - last_b) != gap_pat[(cnt_b - 1) % 3]) bad_gap++;
        last_b = c;
        cnt_b++;
      end
    end
    chk("b_first_strobe", first_b, 4);
    chk("b_strobes_800", cnt_b, 300);
    chk("b_gap_errors", bad_gap, 0);
    // u_a starved the whole time: increments on cycles 5,9,...,801.
    chk("a_free_cnt", ifa.underrun_cnt, 200);
    chk("a_free_underrun", ifa.underrun, 1);

    // Mid-operation reset takes effect without waiting for a clock edge.
    @(negedge clk_pixel);
    sys_nrst = 1'b0;
    #1;
    chk("midrst_a_cnt", ifa.underrun_cnt, 0);
    chk("midrst_a_underrun", ifa.underrun, 0);
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    sys_nrst = 1'b1;

    // Rate 1/4: tick at cycle 4, strobe at cycle 5, then every 4th cycle.
    for (int j = 1; j <= 13; j++) begin
      logic e;
      @(negedge clk_pixel);
      e = (j >= 5) && (((j - 5) % 4) == 0);
      chk("a_strobe_timing", ifa.out_strobe, e);
    end
    chk("a_cnt_after13", ifa.underrun_cnt, 3);

    // en low for two cycles: no strobes, phase restarts from 0.
    ifa.en = 1'b0;
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk_pixel);
      chk("a_en_off_strobe", ifa.out_strobe, 0);
    end
    ifa.en = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      logic e;
      @(negedge clk_pixel);
      e = (j == 5) || (j == 9);
      chk("a_en_restart", ifa.out_strobe, e);
    end

    // Filter: one input per tick period, each strobe shows the next state.
    for (int i = 0; i < 4; i++) begin
      ifa.filt_en  = fv[i].fe;
      ifa.in_data  = {fv[i].x1, fv[i].x0};
      ifa.in_valid = 1'b1;
      @(negedge clk_pixel);
      ifa.in_valid = 1'b0;
      wait_strobe(0, "a_filt_wait");
      chk("a_filt_ch0", ifa.out_data[15:0], fv[i].e0);
      chk("a_filt_ch1", ifa.out_data[31:16], fv[i].e1);
      chk("a_filt_cnt", ifa.underrun_cnt, 5);
    end

    // Underrun: clear, then feed only every second tick period.
    ifa.clr = 1'b1;
    @(negedge clk_pixel);
    ifa.clr = 1'b0;
    chk("a_clr_underrun", ifa.underrun, 0);
    chk("a_clr_cnt", ifa.underrun_cnt, 0);
    for (int p = 0; p < 4; p++) begin
      if ((p % 2) == 0) begin
        ifa.in_valid = 1'b1;
        @(negedge clk_pixel);
        ifa.in_valid = 1'b0;
      end
      wait_strobe(0, "a_ur_wait");
      chk("a_ur_cnt", ifa.underrun_cnt, (p + 1) / 2);
      chk("a_ur_flag", ifa.underrun, (p >= 1) ? 1 : 0);
    end

    // clr on a starved tick cycle wins over the increment.
    repeat (3) @(negedge clk_pixel);
    ifa.clr = 1'b1;
    @(negedge clk_pixel);
    ifa.clr = 1'b0;
    chk("a_clrtick_strobe", ifa.out_strobe, 1);
    chk("a_clrtick_flag", ifa.underrun, 0);
    chk("a_clrtick_cnt", ifa.underrun_cnt, 0);

    // Input on the tick cycle: capture shows the old state, new one next strobe.
    ifa.filt_en = 1'b0;
    ifa.in_data = {16'hFF9C, 16'h0064};
    repeat (3) @(negedge clk_pixel);
    ifa.in_valid = 1'b1;
    @(negedge clk_pixel);
    ifa.in_valid = 1'b0;
    chk("a_coinc_strobe", ifa.out_strobe, 1);
    chk("a_coinc_old", ifa.out_data, 32'hFC18_03E8);
    wait_strobe(0, "a_coinc_wait");
    chk("a_coinc_new", ifa.out_data, 32'hFF9C_0064);
    chk("a_coinc_cnt", ifa.underrun_cnt, 1);

    // Conversion vectors on u_b (narrow) and u_c (wide).
    ifb.in_valid = 1'b1;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifb.in_data = cv[i].x;
      ifc.in_data = cv[i].x;
      wait_strobe(1, "b_conv_wait");
      wait_strobe(1, "b_conv_wait");
      chk("b_conv12", ifb.out_data, cv[i].exp12);
      chk("c_conv24", ifc.out_data, cv[i].exp24);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hdmi_audio_rate_sampler.md
Name: hdmi_audio_rate_sampler

Overview:
Parametrised audio front end for the HDMI audio path. It replaces the fixed modulo-count sample latch with a fractional-N phase accumulator that produces an exact audio-rate tick from clk_pixel. Each channel has an optional first-order IIR smoothing filter, followed by round/saturate width conversion and underrun monitoring. It sits between the FM demodulator's L/R sample stream and the HDMI packetiser's audio_sample inputs.

Parameters:
CHANNELS, 2, number of audio channels packed in in_data/out_data (1..8)
IN_WIDTH, 16, signed bits per input channel
OUT_WIDTH, 16, signed bits per output channel (8..24)
PHASE_W, 32, phase accumulator width
RATE_INC, 48000, phase increment per clk_pixel cycle (0 < RATE_INC < RATE_MOD)
RATE_MOD, 25175000, phase modulus; tick rate = f(clk_pixel) * RATE_INC / RATE_MOD
SHIFT, 2, IIR coefficient as 2^-SHIFT (0..8); SHIFT=0 means pass-through

Ports:
clk_pixel  in  1  sole clock
sys_nrst  in  1  asynchronous active-low reset
en  in  1  1 = phase accumulator runs; 0 = phase forced to 0, no ticks
filt_en  in  1  1 = IIR active; 0 = state loads raw input
in_valid  in  1  one-cycle qualifier for in_data (no backpressure)
in_data  in  CHANNELS*IN_WIDTH  channel k at bits [k*IN_WIDTH +: IN_WIDTH], signed
out_strobe  out  1  one-cycle pulse; out_data is updated on this cycle
out_data  out  CHANNELS*OUT_WIDTH  held converted samples, same packing
underrun  out  1  sticky; set when a tick finds no new input since the previous tick
underrun_cnt  out  16  saturating count of underrun ticks
clr  in  1  synchronous clear of underrun and underrun_cnt (priority over set)

Behaviour:
- Reset (async, sys_nrst=0): phase, filter states, out_data, out_strobe, underrun, underrun_cnt and the fresh flag are all 0.
- Phase: each cycle with en=1, if phase+RATE_INC >= RATE_MOD then phase <= phase+RATE_INC-RATE_MOD and tick=1 (registered); otherwise phase <= phase+RATE_INC and tick=0. Compare at PHASE_W+1 bits, so there is no wrap error. With en=0, phase <= 0 and tick=0.
- Filter state per channel: signed, IN_WIDTH+SHIFT+1 bits, with SHIFT fractional bits. On in_valid:
  - filt_en=1: st <= st + (((x<<<SHIFT) - st) >>> SHIFT).
  - filt_en=0: st <= x<<<SHIFT.
  - No in_valid: st holds.
- Capture: on the cycle after tick=1, out_data <= conv(st>>>SHIFT) and out_strobe=1. Total latency is 1 cycle from tick. If in_valid and tick coincide, capture uses the pre-update state; the new input counts as fresh for the next tick.
- Conversion, OUT_WIDTH >= IN_WIDTH: sign-extend and append OUT_WIDTH-IN_WIDTH zero LSBs.
- Conversion, OUT_WIDTH < IN_WIDTH: add 2^(IN_WIDTH-OUT_WIDTH-1), arithmetic right shift by IN_WIDTH-OUT_WIDTH. If the result exceeds the maximum positive value, saturate to 2^(OUT_WIDTH-1)-1. Negative saturation cannot occur.
- Fresh flag: set by in_valid, cleared on tick. If in_valid arrives on the tick cycle, fresh stays 1.
- Underrun: if tick=1 and fresh=0, then underrun <= 1 and underrun_cnt increments, saturating at 0xFFFF. A clr on the same cycle wins, leaving both at 0.
- en dropping mid-period discards the partial phase. out_data holds its last value; filter states keep running on in_valid.
- Reset mid-operation returns everything to the reset values immediately; the first tick after release occurs at cycle ceil(RATE_MOD/RATE_INC).
- Only a single clock domain exists. in_valid source rate must be ≤ clk_pixel rate; no CDC inside.

Test Plan:
- RATE_INC=1, RATE_MOD=4, en=1 from reset -> out_strobe every 4th cycle, first tick at cycle 4 after release, strobe at cycle 5; en=0 for 2 cycles -> no strobe, restart counts from 0.
- RATE_INC=3, RATE_MOD=8 -> exactly 3 strobes per 8 cycles, spacing pattern 3,3,2 repeating, over 800 cycles = 300 strobes.
- SHIFT=2, filt_en=1, in_valid every cycle with x=1000 (ch0) -> filtered integer 250, 437, 578 on successive updates; filt_en=0 -> next capture 1000.
- IN_WIDTH=16, OUT_WIDTH=12, filt_en=0: input 0x7FF8 -> 0x7FF (saturated); 0xFFFF -> 0x000; 0x8000 -> 0x800; 0x0018 -> 0x002. OUT_WIDTH=24: 0x8001 -> 0x800100.
- Feed in_valid only every second tick period -> underrun=1, underrun_cnt increments once per starved tick; clr asserted on a starved tick -> both read 0 next cycle.
- CHANNELS=2, ch0=+100, ch1=-100 with in_valid asserted on a tick cycle -> captured value is the previous state, new value appears at the following strobe; channels never swap.
